// File: rtl/mipsfpga_ahb_gpio_irq_if.sv
// Simplified single-cycle AHB-Lite slave bus used by the GPIO/IRQ block.
// The decoder (or bench) drives the master side; the GPIO block is the slave.
interface mipsfpga_ahb_gpio_irq_if;
    logic [3:0]  HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic        HSEL;
    logic [31:0] HRDATA;

    modport master (
        output HADDR,
        output HWDATA,
        output HWRITE,
        output HSEL,
        input  HRDATA
    );

    modport slave (
        input  HADDR,
        input  HWDATA,
        input  HWRITE,
        input  HSEL,
        output HRDATA
    );
endinterface

// File: rtl/mipsfpga_ahb_gpio_irq.sv
// GPIO slave with atomic set/clear/toggle outputs, synchronised and debounced
// inputs, and a sticky write-1-to-clear edge interrupt with a level irq output.
module mipsfpga_ahb_gpio_irq #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DB_W      = 16,
    parameter int unsigned      DB_RESET  = 50000,
    parameter logic [WIDTH-1:0] OUT_RESET = '0
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    mipsfpga_ahb_gpio_irq_if.slave bus,
    input  logic [WIDTH-1:0]       gpio_in,
    output logic [WIDTH-1:0]       gpio_out,
    output logic                   irq
);

    // Register indices as seen on HADDR.
    typedef enum logic [3:0] {
        REG_OUT        = 4'd0,
        REG_OUT_SET    = 4'd1,
        REG_OUT_CLR    = 4'd2,
        REG_OUT_TGL    = 4'd3,
        REG_IN         = 4'd4,
        REG_RISE_EN    = 4'd5,
        REG_FALL_EN    = 4'd6,
        REG_IRQ_STATUS = 4'd7,
        REG_DEBOUNCE   = 4'd8
    } reg_idx_e;

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic             wr_en;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] w1c;

    assign wr_en = bus.HSEL & bus.HWRITE;
    assign wdata = bus.HWDATA[WIDTH-1:0];
    assign w1c   = (wr_en && bus.HADDR == REG_IRQ_STATUS) ? wdata : '0;

    // Write-data bits at WIDTH and above carry no meaning for this block.
    logic unused_hwdata;
    assign unused_hwdata = ^bus.HWDATA;

    // ------------------------------------------------------------------
    // Architectural registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] irq_status;
    logic [DB_W-1:0]  db_n;

    // Output port: plain write plus atomic set/clear/toggle, visible on the write edge.
    // NOTE: every clocked register uses <= so all flops sample pre-edge values
    //       together; a blocking = here would let later statements see new state.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            out_q <= OUT_RESET;
        end else if (wr_en) begin
            case (bus.HADDR)
                REG_OUT:     out_q <= wdata;
                REG_OUT_SET: out_q <= out_q | wdata;
                REG_OUT_CLR: out_q <= out_q & ~wdata;
                REG_OUT_TGL: out_q <= out_q ^ wdata;
                default:     ;
            endcase
        end
    end

    assign gpio_out = out_q;

    // Edge enables and debounce length; a new length applies from the next edge.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rise_en <= '0;
            fall_en <= '0;
            db_n    <= DB_W'(DB_RESET);
        end else if (wr_en) begin
            case (bus.HADDR)
                REG_RISE_EN:  rise_en <= wdata;
                REG_FALL_EN:  fall_en <= wdata;
                REG_DEBOUNCE: db_n    <= bus.HWDATA[DB_W-1:0];
                default:      ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Input path: two-flop synchroniser, per-bit debounce, edge history
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_d;
    logic [DB_W-1:0]  cnt [WIDTH];
    logic             db_short;
    logic [DB_W-1:0]  db_lim;

    // N of 0 or 1 both mean "accept after one differing sample"; db_lim is
    // only consulted when N >= 2, so the subtraction never wraps.
    assign db_short = (db_n <= DB_W'(1));
    assign db_lim   = db_n - DB_W'(1);

    // Synchronise, then promote s2 into stable once it has differed for N samples.
    // NOTE: the counter array is reset with everything else so a reset in the
    //       middle of a debounce window leaves no partial count behind.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            sync1    <= '0;
            sync2    <= '0;
            stable   <= '0;
            stable_d <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= gpio_in;
            sync2    <= sync1;
            stable_d <= stable;
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (db_short || cnt[i] >= db_lim) begin
                    // >= rather than == so shrinking N mid-count still releases the bit.
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + DB_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Edge detection and sticky interrupt status
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;

    assign rise = stable & ~stable_d;
    assign fall = ~stable & stable_d;

    // Enabled edges set status; W1C clears, but a same-edge set wins.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~w1c) | (rise & rise_en) | (fall & fall_en);
        end
    end

    assign irq = |irq_status;

    // ------------------------------------------------------------------
    // Read mux: combinational from HADDR, shows pre-edge register state
    // ------------------------------------------------------------------
    logic [31:0] rdata;

    // Zero-extended read of the addressed register; write-only and unused indices read 0.
    // NOTE: rdata gets a default before the case so no path leaves it
    //       unassigned, which would otherwise infer a latch.
    always_comb begin
        rdata = '0;
        case (bus.HADDR)
            REG_OUT:        rdata[WIDTH-1:0] = out_q;
            REG_IN:         rdata[WIDTH-1:0] = stable;
            REG_RISE_EN:    rdata[WIDTH-1:0] = rise_en;
            REG_FALL_EN:    rdata[WIDTH-1:0] = fall_en;
            REG_IRQ_STATUS: rdata[WIDTH-1:0] = irq_status;
            REG_DEBOUNCE:   rdata[DB_W-1:0]  = db_n;
            default:        ;
        endcase
    end

    assign bus.HRDATA = rdata;

endmodule
